// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned BUF_ENTRIES = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned CNT_NW      = CNT_W + 1;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_WAIT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry tagged instruction buffer: pc lookup, pc+4 presence lookup, fill port, lru.
module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pf_addr,
    input  logic            i_fill,
    input  logic            i_fill_pf,
    input  logic [XLEN-1:0] i_fill_tag,
    input  logic [XLEN-1:0] i_fill_data,
    output logic            o_hit,
    output logic [XLEN-1:0] o_hit_data,
    output logic            o_pf_present
);

    logic [BUF_ENTRIES-1:0] r_valid;
    logic [XLEN-1:0]        r_tag  [BUF_ENTRIES];
    logic [XLEN-1:0]        r_data [BUF_ENTRIES];
    logic                   r_lru;

    logic [BUF_ENTRIES-1:0] w_hit_vec;
    logic [BUF_ENTRIES-1:0] w_pf_vec;
    logic                   w_hit_idx;
    logic                   w_victim;

    always_comb begin
        w_hit_vec = '0;
        w_pf_vec  = '0;
        for (int i = 0; i < BUF_ENTRIES; i++) begin
            w_hit_vec[i] = r_valid[i] && (r_tag[i] == i_pc);
            w_pf_vec[i]  = r_valid[i] && (r_tag[i] == i_pf_addr);
        end
    end

    // Tags are unique (fills only target absent addresses), so at most one entry hits.
    assign w_hit_idx    = w_hit_vec[1];
    assign o_hit        = |w_hit_vec;
    assign o_hit_data   = r_data[w_hit_idx];
    assign o_pf_present = |w_pf_vec;

    // A prefetch must not evict the word the core is currently executing.
    assign w_victim = (i_fill_pf && o_hit) ? ~w_hit_idx : r_lru;

    // A freshly filled entry counts as most recently used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_lru   <= 1'b0;
            for (int i = 0; i < BUF_ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_fill) begin
            r_valid[w_victim] <= 1'b1;
            r_tag[w_victim]   <= i_fill_tag;
            r_data[w_victim]  <= i_fill_data;
            r_lru             <= ~w_victim;
        end else if (o_hit) begin
            r_lru <= ~w_hit_idx;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: buffer lookup, demand/prefetch FSM and memory timeout.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter bit              PREFETCH = 1'b1,
    parameter int unsigned     TIMEOUT  = 255,
    parameter logic [XLEN-1:0] NOP_WORD = instr_fetch_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instruction,
    output logic            instr_valid,
    output logic            freeze,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic            r_req;
    logic            w_req_next;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic            r_err;
    logic            w_err_next;
    logic            r_pf;
    logic            w_pf_next;

    logic            w_hit;
    logic [XLEN-1:0] w_hit_data;
    logic            w_pf_present;
    logic [XLEN-1:0] w_pf_addr;
    logic            w_misaligned;
    logic            w_fill;
    logic [CNT_NW-1:0] w_cnt_inc;

    assign w_pf_addr    = pc + XLEN'(4);
    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_fill       = (r_state == FETCH_WAIT) && imem_ack;
    assign w_cnt_inc    = {1'b0, r_cnt} + CNT_NW'(1);

    fetch_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (pc),
        .i_pf_addr    (w_pf_addr),
        .i_fill       (w_fill),
        .i_fill_pf    (r_pf),
        .i_fill_tag   (r_addr),
        .i_fill_data  (imem_rdata),
        .o_hit        (w_hit),
        .o_hit_data   (w_hit_data),
        .o_pf_present (w_pf_present)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An outstanding request always runs to ack or timeout, even if pc moves away.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_addr_next  = r_addr;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_pf_next    = r_pf;
        case (r_state)
            FETCH_IDLE: begin
                w_cnt_next = '0;
                if (w_misaligned) begin
                    w_err_next = 1'b1;
                end else if (!w_hit) begin
                    w_req_next   = 1'b1;
                    w_addr_next  = pc;
                    w_pf_next    = 1'b0;
                    w_state_next = FETCH_WAIT;
                end else if (PREFETCH && !w_pf_present) begin
                    w_req_next   = 1'b1;
                    w_addr_next  = w_pf_addr;
                    w_pf_next    = 1'b1;
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_ack) begin
                    w_req_next   = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = FETCH_IDLE;
                end else if (w_cnt_inc == CNT_NW'(TIMEOUT)) begin
                    w_req_next   = 1'b0;
                    w_err_next   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = FETCH_IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_pf   <= 1'b0;
        end else begin
            r_req  <= w_req_next;
            r_addr <= w_addr_next;
            r_cnt  <= w_cnt_next;
            r_err  <= w_err_next;
            r_pf   <= w_pf_next;
        end
    end

    assign instr_valid = w_hit && !rst;
    assign instruction = instr_valid ? w_hit_data : NOP_WORD;
    assign freeze      = !instr_valid;
    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a bench-side instruction memory of programmable latency.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        freeze;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    bit mem_en  = 1'b1;
    int mem_lat = 1;
    int wcnt    = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .PREFETCH (1'b1),
        .TIMEOUT  (4),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .freeze      (freeze),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .fetch_err   (fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h3e80_0093 : (a ^ 32'hC0DE_0000);
    endfunction

    // Advance one clock; the memory acks after mem_lat extra cycles of a held request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_en && imem_req) begin
            if (wcnt == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] p);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pc  = p;
        #1;
    endtask

    task automatic test_reset();
        mem_en  = 1'b1;
        mem_lat = 1;
        rst     = 1'b1;
        pc      = 32'h0;
        tick();
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (freeze !== 1'b1) begin bad++; $display("FAIL rst_freeze got=%b exp=1", freeze); end
        total++; if (instruction !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instruction); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
        rst = 1'b0;
        #1;
    endtask

    // Continues straight out of reset with pc=0; memory acks one cycle after the request.
    task automatic test_demand_miss();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            total++; if (freeze !== 1'b1) begin bad++; $display("FAIL miss_freeze c%0d got=%b exp=1", c, freeze); end
            if (c == 1) begin
                total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL miss_req got=%b exp=1", imem_req); end
            end
        end
        tick();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL miss_valid got=%b exp=1", instr_valid); end
        total++; if (instruction !== 32'h3e80_0093) begin bad++; $display("FAIL miss_instr got=%h exp=3e800093", instruction); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL miss_addr got=%h exp=00000000", imem_addr); end
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL miss_unfreeze got=%b exp=0", freeze); end
    endtask

    task automatic test_prefetch();
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL pf_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL pf_addr got=%h exp=00000004", imem_addr); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL pf_still_hit got=%b exp=1", instr_valid); end
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL pf_req_drop got=%b exp=0", imem_req); end
        pc = 32'h4;
        #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL pf_hit4 got=%b exp=1", instr_valid); end
        total++; if (instruction !== 32'hC0DE_0004) begin bad++; $display("FAIL pf_instr4 got=%h exp=c0de0004", instruction); end
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL pf_freeze4 got=%b exp=0", freeze); end
    endtask

    task automatic test_pc_change();
        tick();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL jmp_pf8_addr got=%h exp=00000008", imem_addr); end
        pc = 32'h3E8;
        #1;
        total++; if (freeze !== 1'b1) begin bad++; $display("FAIL jmp_freeze got=%b exp=1", freeze); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL jmp_hold req=%b addr=%h exp 1/00000008", imem_req, imem_addr); end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL jmp_idle_req got=%b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3E8) begin bad++; $display("FAIL jmp_demand req=%b addr=%h exp 1/000003e8", imem_req, imem_addr); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL jmp_early_valid got=%b exp=0", instr_valid); end
        tick();
        total++; if (instruction !== 32'hC0DE_03E8) begin bad++; $display("FAIL jmp_instr got=%h exp=c0de03e8", instruction); end
        pc = 32'h8;
        #1;
        total++; if (instruction !== 32'hC0DE_0008 || instr_valid !== 1'b1) begin bad++; $display("FAIL jmp_kept8 instr=%h valid=%b exp c0de0008/1", instruction, instr_valid); end
        pc = 32'h4;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL jmp_evict4 got=%b exp=0", instr_valid); end
    endtask

    task automatic test_misaligned();
        do_reset(32'h7D2);
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL mis_err0 got=%b exp=0", fetch_err); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL mis_err c%0d got=%b exp=1", c, fetch_err); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req c%0d got=%b exp=0", c, imem_req); end
            total++; if (freeze !== 1'b1) begin bad++; $display("FAIL mis_freeze c%0d got=%b exp=1", c, freeze); end
        end
    endtask

    task automatic test_timeout();
        mem_en = 1'b0;
        do_reset(32'h100);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_req0 got=%b exp=0", imem_req); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin bad++; $display("FAIL to_wait c%0d req=%b err=%b exp 1/0", c, imem_req, fetch_err); end
        end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_drop got=%b exp=0", imem_req); end
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", fetch_err); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL to_retry req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", fetch_err); end
        mem_en = 1'b1;
    endtask

    task automatic test_zero_wait();
        mem_lat = 0;
        do_reset(32'h200);
        total++; if (freeze !== 1'b1) begin bad++; $display("FAIL zw_freeze0 got=%b exp=1", freeze); end
        tick();
        total++; if (freeze !== 1'b1 || imem_req !== 1'b1) begin bad++; $display("FAIL zw_cycle1 freeze=%b req=%b exp 1/1", freeze, imem_req); end
        tick();
        total++; if (instruction !== 32'hC0DE_0200 || instr_valid !== 1'b1) begin bad++; $display("FAIL zw_hit instr=%h valid=%b exp c0de0200/1", instruction, instr_valid); end
        tick();
        total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL zw_pf_addr got=%h exp=00000204", imem_addr); end
        tick();
        pc = 32'h204;
        #1;
        total++; if (instruction !== 32'hC0DE_0204 || freeze !== 1'b0) begin bad++; $display("FAIL zw_seq instr=%h freeze=%b exp c0de0204/0", instruction, freeze); end
        mem_lat = 1;
    endtask

    task automatic test_wrap_rst_ack();
        mem_lat = 1;
        do_reset(32'hFFFF_FFFC);
        tick();
        tick();
        tick();
        total++; if (instruction !== 32'h3F21_FFFC) begin bad++; $display("FAIL wrap_instr got=%h exp=3f21fffc", instruction); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pf req=%b addr=%h exp 1/00000000", imem_req, imem_addr); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstack_req got=%b exp=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rstack_inval got=%b exp=0", instr_valid); end
        pc = 32'h0;
        #1;
        total++; if (instr_valid !== 1'b0 || instruction !== 32'h0000_0013) begin bad++; $display("FAIL rstack_discard valid=%b instr=%h exp 0/00000013", instr_valid, instruction); end
    endtask

    initial begin
        test_reset();
        test_demand_miss();
        test_prefetch();
        test_pc_change();
        test_misaligned();
        test_timeout();
        test_zero_wait();
        test_wrap_rst_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
